// File: rtl/iir_sos_sched.sv
// Sequencer that runs one sample through NSEC cascaded biquad sections on a
// single shared engine, with a saturating drop counter and a sticky timeout flag.
module iir_sos_sched #(
  parameter int DW   = 24,
  parameter int NSEC = 4,
  parameter int IW   = 2,
  parameter int TMO  = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NSEC*IW-1:0]       sos_map,
  output logic                     eng_start,
  output logic [IW-1:0]            eng_sec,
  output logic [DW-1:0]            eng_x,
  input  logic                     eng_done,
  input  logic [DW-1:0]            eng_y,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic [$clog2(NSEC)-1:0]  cur_sec,
  output logic [15:0]              drop_cnt,
  output logic                     err,
  input  logic                     clr_stat
);

  localparam int SW = $clog2(NSEC);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        acc_q, acc_d;
  logic [DW-1:0]        eng_x_q, eng_x_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [IW-1:0]        eng_sec_q, eng_sec_d;
  logic [NSEC*IW-1:0]   map_q, map_d;
  logic [SW-1:0]        sec_cnt_q, sec_cnt_d;
  logic [SW-1:0]        sec_nxt;
  logic [TW-1:0]        timer_q, timer_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 err_q, err_d;
  logic                 last_sec;
  logic                 timeout;

  assign sec_nxt  = sec_cnt_q + 1'b1;
  assign last_sec = (sec_cnt_q == SW'(NSEC - 1));
  // The TMO-th WAIT cycle without eng_done is the last chance; a done there still wins.
  assign timeout  = (state_q == WAIT) && !eng_done && (timer_q == TW'(TMO - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      eng_x_q    <= '0;
      out_data_q <= '0;
      eng_sec_q  <= '0;
      map_q      <= '0;
      sec_cnt_q  <= '0;
      timer_q    <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      eng_x_q    <= eng_x_d;
      out_data_q <= out_data_d;
      eng_sec_q  <= eng_sec_d;
      map_q      <= map_d;
      sec_cnt_q  <= sec_cnt_d;
      timer_q    <= timer_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state and datapath. eng_sec/eng_x are loaded on entry to ISSUE and then held.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    eng_x_d    = eng_x_q;
    out_data_d = out_data_q;
    eng_sec_d  = eng_sec_q;
    map_d      = map_q;
    sec_cnt_d  = sec_cnt_q;
    timer_d    = timer_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d     = in_data;
          map_d     = sos_map;
          sec_cnt_d = '0;
          timer_d   = '0;
          eng_sec_d = sos_map[IW-1:0];
          eng_x_d   = in_data;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (eng_done) begin
          acc_d = eng_y;
          if (last_sec) begin
            out_data_d = eng_y;
            state_d    = OUT;
          end else begin
            sec_cnt_d = sec_nxt;
            eng_sec_d = map_q[IW*int'(sec_nxt) +: IW];
            eng_x_d   = eng_y;
            state_d   = ISSUE;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      OUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Statistics; clr_stat overrides a same-cycle increment or timeout.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q | timeout;
    if (in_valid && !in_ready && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    if (clr_stat) begin
      drop_cnt_d = '0;
      err_d      = 1'b0;
    end
  end

  // Outputs decoded from the state; in_ready is also held low during reset.
  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    eng_start = (state_q == ISSUE);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  assign eng_sec  = eng_sec_q;
  assign eng_x    = eng_x_q;
  assign out_data = out_data_q;
  assign cur_sec  = sec_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_iir_sos_sched.sv
// Directed bench for iir_sos_sched with a latency-programmable y=x+1 engine model.
module tb_iir_sos_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  sos_map;
  logic        eng_start;
  logic [1:0]  eng_sec;
  logic [23:0] eng_x;
  logic        eng_done = 1'b0;
  logic [23:0] eng_y = '0;
  logic [23:0] out_data;
  logic        out_valid;
  logic        busy;
  logic [1:0]  cur_sec;
  logic [15:0] drop_cnt;
  logic        err;
  logic        clr_stat;

  int errors = 0;
  int checks = 0;

  iir_sos_sched #(.DW(24), .NSEC(4), .IW(2), .TMO(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sos_map(sos_map), .eng_start(eng_start), .eng_sec(eng_sec), .eng_x(eng_x),
    .eng_done(eng_done), .eng_y(eng_y), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .cur_sec(cur_sec), .drop_cnt(drop_cnt), .err(err), .clr_stat(clr_stat)
  );

  always #5 clk = ~clk;

  // Engine model and monitors
  int          lat = 1;
  bit          eng_en = 1'b1;
  bit          spurious = 1'b0;
  int          eng_cnt = 0;
  logic [23:0] eng_hold = '0;
  int          cyc = 0;
  int          n_log = 0, n_acc = 0, out_cnt = 0, low_cnt = 0;
  logic [1:0]  log_sec [128];
  logic [1:0]  log_cur [128];
  logic [23:0] log_x   [128];
  int          log_cyc [128];
  int          acc_edge[128];
  logic [23:0] outs    [128];
  int          out_cyc [128];

  always @(posedge clk) begin
    if (in_valid && in_ready && n_acc < 128) begin
      acc_edge[n_acc] = cyc + 1;
      n_acc++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_y    = eng_hold + 24'd1;
      end
    end
    if (eng_start && n_log < 128) begin
      log_sec[n_log] = eng_sec;
      log_cur[n_log] = cur_sec;
      log_x[n_log]   = eng_x;
      log_cyc[n_log] = cyc;
      n_log++;
      if (eng_en) begin
        eng_cnt  = lat;
        eng_hold = eng_x;
      end
      if (spurious) begin
        eng_done = 1'b1;
        eng_y    = 24'h0003E7;
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_cnt < 128) begin
      outs[out_cnt]    = out_data;
      out_cyc[out_cnt] = cyc;
      out_cnt++;
    end
    if (!in_ready) low_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [23:0] v);
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle wait: busy=%b after %0d cycles, required 0", tag, busy, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sos_map = 8'hE4; clr_stat = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, eng_start, eng_sec, eng_x, out_data, out_valid, busy, cur_sec, drop_cnt, err} !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b st=%b sec=%0d x=%0h out=%0h ov=%b busy=%b cs=%0d drop=%0d err=%b, required all 0",
               in_ready, eng_start, eng_sec, eng_x, out_data, out_valid, busy, cur_sec, drop_cnt, err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    int b = n_log, a = n_acc, o = out_cnt, lc = low_cnt;
    lat = 1; eng_en = 1'b1; spurious = 1'b0; sos_map = 8'hE4;
    send(24'd100);
    wait_idle(50, "basic");
    checks++;
    if (n_log - b !== 4) begin errors++; $display("FAIL basic_starts: got %0d required 4", n_log - b); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_sec[b+i] !== 2'(i) || log_cur[b+i] !== 2'(i) || log_x[b+i] !== 24'(100 + i) ||
          log_cyc[b+i] - acc_edge[a] !== 2 * i) begin
        errors++;
        $display("FAIL basic_issue%0d: sec=%0d cur=%0d x=%0d at E+%0d, required sec=%0d x=%0d at E+%0d",
                 i, log_sec[b+i], log_cur[b+i], log_x[b+i], log_cyc[b+i] - acc_edge[a], i, 100 + i, 2 * i);
      end
    end
    checks++;
    if (out_cnt - o !== 1 || outs[o] !== 24'd104 || out_cyc[o] - acc_edge[a] !== 8) begin
      errors++;
      $display("FAIL basic_out: count=%0d data=%0d at E+%0d, required 1 / 104 / E+8",
               out_cnt - o, outs[o], out_cyc[o] - acc_edge[a]);
    end
    checks++;
    if (low_cnt - lc !== 9) begin errors++; $display("FAIL basic_ready_low: got %0d cycles required 9", low_cnt - lc); end
    checks++;
    if (eng_sec !== 2'd3 || eng_x !== 24'd103 || out_data !== 24'd104) begin
      errors++;
      $display("FAIL basic_hold: sec=%0d x=%0d out=%0d required 3 / 103 / 104", eng_sec, eng_x, out_data);
    end
  endtask

  task automatic test_long_latency();
    int b = n_log, a = n_acc, o = out_cnt;
    lat = 5; spurious = 1'b1;
    send(24'(-7));
    wait_idle(80, "long");
    spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_x[b+i] !== 24'(-7 + i) || log_cyc[b+i] - acc_edge[a] !== 6 * i) begin
        errors++;
        $display("FAIL long_issue%0d: x=%0h at E+%0d, required %0h at E+%0d",
                 i, log_x[b+i], log_cyc[b+i] - acc_edge[a], 24'(-7 + i), 6 * i);
      end
    end
    checks++;
    if (out_cnt - o !== 1 || outs[o] !== 24'hFFFFFD || out_cyc[o] - acc_edge[a] !== 24) begin
      errors++;
      $display("FAIL long_out: count=%0d data=%0h at E+%0d, required 1 / fffffd / E+24",
               out_cnt - o, outs[o], out_cyc[o] - acc_edge[a]);
    end
  endtask

  task automatic test_back_to_back();
    int a = n_acc, o = out_cnt;
    lat = 1;
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      in_data = 24'(1000 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle(30, "b2b");
    checks++;
    if (n_acc - a !== 3 || acc_edge[a+1] - acc_edge[a] !== 10 || acc_edge[a+2] - acc_edge[a] !== 20) begin
      errors++;
      $display("FAIL b2b_accepts: count=%0d offsets %0d,%0d required 3 at +10,+20",
               n_acc - a, acc_edge[a+1] - acc_edge[a], acc_edge[a+2] - acc_edge[a]);
    end
    checks++;
    if (drop_cnt !== 16'd27) begin errors++; $display("FAIL b2b_drop_cnt: got %0d required 27", drop_cnt); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outs[o+k] !== 24'(1004 + 10 * k)) begin
        errors++;
        $display("FAIL b2b_out%0d: got %0d required %0d", k, outs[o+k], 1004 + 10 * k);
      end
    end
  endtask

  task automatic test_drop_saturation();
    @(negedge clk);
    in_data  = 24'd5;
    in_valid = 1'b1;
    @(negedge clk);
    force dut.drop_cnt_q = 16'hFFFD;
    #1;
    release dut.drop_cnt_q;
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_step: got %0h required fffe", drop_cnt); end
    repeat (3) @(negedge clk);
    checks++;
    if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h required ffff", drop_cnt); end
    in_valid = 1'b0;
    wait_idle(20, "sat");
  endtask

  task automatic test_timeout();
    int o = out_cnt, b = n_log;
    eng_en = 1'b0;
    send(24'd7);
    repeat (8) @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: err=%b busy=%b after 8 WAIT-1 cycles, required 0/1", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || out_cnt !== o || n_log - b !== 1) begin
      errors++;
      $display("FAIL tmo_fire: err=%b busy=%b rdy=%b outs=%0d starts=%0d, required 1/0/1/0/1",
               err, busy, in_ready, out_cnt - o, n_log - b);
    end
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    checks++;
    if (err !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL tmo_clear: err=%b drop=%0h required 0/0", err, drop_cnt);
    end
    send(24'd8);
    repeat (8) @(negedge clk);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clr_wins: err=%b busy=%b required 0/0", err, busy);
    end
    eng_en = 1'b1;
  endtask

  task automatic test_done_at_tmo();
    int a = n_acc, o = out_cnt;
    lat = 8;
    send(24'd1);
    wait_idle(60, "done_at_tmo");
    checks++;
    if (err !== 1'b0 || out_cnt - o !== 1 || outs[o] !== 24'd5 || out_cyc[o] - acc_edge[a] !== 36) begin
      errors++;
      $display("FAIL done_at_tmo: err=%b count=%0d data=%0d at E+%0d, required 0 / 1 / 5 / E+36",
               err, out_cnt - o, outs[o], out_cyc[o] - acc_edge[a]);
    end
    lat = 1;
  endtask

  task automatic test_map_change();
    int b = n_log, o = out_cnt;
    sos_map = 8'hE4;
    send(24'd200);
    sos_map = 8'h1B;
    wait_idle(30, "map1");
    send(24'd300);
    wait_idle(30, "map2");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_sec[b+i] !== 2'(i) || log_sec[b+4+i] !== 2'(3 - i) || log_x[b+4+i] !== 24'(300 + i)) begin
        errors++;
        $display("FAIL map_sec%0d: first=%0d second=%0d x=%0d, required %0d / %0d / %0d",
                 i, log_sec[b+i], log_sec[b+4+i], log_x[b+4+i], i, 3 - i, 300 + i);
      end
    end
    checks++;
    if (outs[o] !== 24'd204 || outs[o+1] !== 24'd304) begin
      errors++;
      $display("FAIL map_out: got %0d,%0d required 204,304", outs[o], outs[o+1]);
    end
  endtask

  task automatic test_mid_reset();
    int b, o, a;
    send(24'd50);
    repeat (5) @(negedge clk);
    checks++;
    if (cur_sec !== 2'd2 || busy !== 1'b1 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: cur_sec=%0d busy=%b start=%b required 2/1/0", cur_sec, busy, eng_start);
    end
    rst_n = 1'b0;
    #1;
    b = n_log; o = out_cnt;
    checks++;
    if ({in_ready, eng_start, eng_sec, eng_x, out_data, out_valid, busy, cur_sec, drop_cnt, err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: rdy=%b st=%b sec=%0d x=%0h out=%0h ov=%b busy=%b cs=%0d drop=%0d err=%b, required all 0",
               in_ready, eng_start, eng_sec, eng_x, out_data, out_valid, busy, cur_sec, drop_cnt, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (n_log !== b || out_cnt !== o || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_abort: starts=%0d outs=%0d rdy=%b, required 0/0/1", n_log - b, out_cnt - o, in_ready);
    end
    a = n_acc;
    send(24'd50);
    wait_idle(30, "mid_after");
    checks++;
    if (out_cnt - o !== 1 || outs[o] !== 24'd54 || out_cyc[o] - acc_edge[a] !== 8) begin
      errors++;
      $display("FAIL mid_after_out: count=%0d data=%0d at E+%0d, required 1 / 54 / E+8",
               out_cnt - o, outs[o], out_cyc[o] - acc_edge[a]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_latency();
    test_back_to_back();
    test_drop_saturation();
    test_timeout();
    test_done_at_tmo();
    test_map_change();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
